// File: rtl/yu_fetch_pkg.sv
// yu_fetch_pkg: shared fetch-stage state encoding and PC constants
package yu_fetch_pkg;
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} fetch_state_t;
  localparam int PC_STEP = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/adder.sv
// Adder: plain modular adder used for the PC increment
module Adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/pc_boot_timer.sv
// pc_boot_timer: counts post-reset idle cycles, done is high in the last one
module pc_boot_timer #(
  parameter int DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done
);
  logic [3:0] cnt;
  assign done = en && cnt == 4'(DELAY - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (en && !done) cnt <= cnt + 4'd1;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: PC owner and single-outstanding fetch controller
// PC_SEQ_MISALIGN_TRAP_EN: misaligned redirects raise a sticky error and halt fetch
module pc_fetch_sequencer import yu_fetch_pkg::*; #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int BOOT_DELAY = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            misalign_err
);
  fetch_state_t state, state_nx;
  logic [XLEN-1:0] pc, pc_nx, pc_inc, tgt;
  logic squash, squash_nx, ld, boot_done, trap;
  pc_boot_timer #(.DELAY(BOOT_DELAY)) u_boot (
    .clk(clk), .rst(rst), .en(state == BOOT), .done(boot_done)
  );
  Adder #(.W(XLEN)) u_inc (.a(pc), .b(XLEN'(PC_STEP)), .y(pc_inc));
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign tgt = redirect_target;
  assign trap = misalign_err;
  always_ff @(posedge clk or negedge rst)
    if (!rst) misalign_err <= 1'b0;
    else if (state != BOOT && redirect_valid && redirect_target[1:0] != 2'b00) misalign_err <= 1'b1;
`else
  assign tgt = redirect_target & ~XLEN'(3);
  assign trap = 1'b0;
  assign misalign_err = 1'b0;
`endif
  assign imem_addr = pc;
  assign inst_valid = state == HOLD;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    squash_nx = squash;
    ld = 1'b0;
    imem_req = 1'b0;
    case (state)
      BOOT: state_nx = boot_done ? REQ : BOOT;
      REQ: begin
        imem_req = !redirect_valid && !trap;
        pc_nx = redirect_valid ? tgt : pc;
        state_nx = imem_req && imem_ready ? WAIT : REQ;
      end
      WAIT: begin
        pc_nx = redirect_valid ? tgt : pc;
        ld = imem_rvalid && !squash && !redirect_valid;
        squash_nx = !imem_rvalid && (squash || redirect_valid);
        state_nx = !imem_rvalid ? WAIT : ld ? HOLD : REQ;
      end
      HOLD: begin
        pc_nx = redirect_valid ? tgt : inst_ready ? pc_inc : pc;
        state_nx = redirect_valid || inst_ready ? REQ : HOLD;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= BOOT;
      pc <= RESET_VECTOR;
      squash <= 1'b0;
      inst <= '0;
      inst_pc <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      squash <= squash_nx;
      if (ld) begin
        inst <= imem_rdata;
        inst_pc <= pc;
      end
    end
endmodule
